mul_round_sat: RTL and testbench

Sequencer and post-processing stage that sits directly downstream of the control loop's sequential Booth multiplier. It accepts one operand pair per transaction over a valid/ready handshake and drives the multiplier's arm/operand inputs. It waits for fin, then rounds the full-width two's-complement product to the loop's fixed-point format, saturates it and presents the result over a valid/ready handshake. It turns the multiplier's level-sensitive arm/fin protocol into a pipeline-friendly streaming interface for the PI stage.

---
 rtl/ctrl_fixed_pkg.sv | 23 ++
 rtl/round_sat.sv | 42 ++++
 rtl/mul_round_sat.sv | 131 +++++++++++++
 tb/tb_mul_round_sat.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_fixed_pkg.sv
// ============================================================================
// ctrl_fixed_pkg : shared widths and sequencer state encoding for the control loop
// Rev 1.0
// ============================================================================
`default_nettype none

package ctrl_fixed_pkg;

    localparam int A1_LEN_DEF  = 32;
    localparam int A2_LEN_DEF  = 32;
    localparam int FRAC_DEF    = 16;
    localparam int OUT_LEN_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_WAIT  = 2'd1;
    localparam state_t ST_ROUND = 2'd2;
    localparam state_t ST_OUT   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/round_sat.sv
// ============================================================================
// round_sat : round-half-up a P-bit signed product by FRAC bits and saturate to OUT_LEN
// Rev 1.0
// ============================================================================
`default_nettype none

module round_sat #(
    parameter int P       = 64,
    parameter int FRAC    = 16,
    parameter int OUT_LEN = 32
) (
    input  logic [P-1:0]       prod_i,
    output logic [OUT_LEN-1:0] data_o,
    output logic               sat_o
);

    localparam logic [P:0] ONE = {{P{1'b0}}, 1'b1};
    // Half an output LSB; collapses to zero when FRAC is zero.
    localparam logic [P:0] RND = (ONE << FRAC) >> 1;
    localparam logic signed [P:0] MAXV = {{(P - OUT_LEN + 2){1'b0}}, {(OUT_LEN - 1){1'b1}}};
    localparam logic signed [P:0] MINV = {{(P - OUT_LEN + 2){1'b1}}, {(OUT_LEN - 1){1'b0}}};

    logic signed [P:0] w_r;
    logic signed [P:0] w_q;

    always_comb begin
        w_r    = $signed({prod_i[P-1], prod_i}) + $signed(RND);
        w_q    = w_r >>> FRAC;
        data_o = w_q[OUT_LEN-1:0];
        sat_o  = 1'b0;
        if (w_q > MAXV) begin
            data_o = {1'b0, {(OUT_LEN - 1){1'b1}}};
            sat_o  = 1'b1;
        end else if (w_q < MINV) begin
            data_o = {1'b1, {(OUT_LEN - 1){1'b0}}};
            sat_o  = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mul_round_sat.sv
// ============================================================================
// mul_round_sat : streams operand pairs through the arm/fin Booth multiplier,
//                 then rounds and saturates the product for the PI stage
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_round_sat
    import ctrl_fixed_pkg::*;
#(
    parameter int A1_LEN  = A1_LEN_DEF,
    parameter int A2_LEN  = A2_LEN_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int OUT_LEN = OUT_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [A1_LEN-1:0]          in_a1,
    input  logic [A2_LEN-1:0]          in_a2,
    output logic                       mul_arm,
    output logic [A1_LEN-1:0]          mul_a1,
    output logic [A2_LEN-1:0]          mul_a2,
    input  logic [A1_LEN+A2_LEN-1:0]   mul_prod,
    input  logic                       mul_fin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_LEN-1:0]         out_data,
    output logic                       out_sat
);

    localparam int P = A1_LEN + A2_LEN;

    state_t              state_q, state_d;
    logic                arm_q, arm_d;
    logic [A1_LEN-1:0]   a1_q, a1_d;
    logic [A2_LEN-1:0]   a2_q, a2_d;
    logic [P-1:0]        prod_q, prod_d;
    logic [OUT_LEN-1:0]  data_q, data_d;
    logic                sat_q, sat_d;
    logic                valid_q, valid_d;

    logic [OUT_LEN-1:0]  w_data;
    logic                w_sat;

    round_sat #(
        .P       (P),
        .FRAC    (FRAC),
        .OUT_LEN (OUT_LEN)
    ) u_round_sat (
        .prod_i (prod_q),
        .data_o (w_data),
        .sat_o  (w_sat)
    );

    // A stale fin from the previous product must clear before a new accept.
    assign in_ready  = (state_q == ST_IDLE) && !mul_fin;
    assign mul_arm   = arm_q;
    assign mul_a1    = a1_q;
    assign mul_a2    = a2_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_sat   = sat_q;

    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        prod_d  = prod_q;
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a1_d    = in_a1;
                    a2_d    = in_a2;
                    arm_d   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_fin) begin
                    prod_d  = mul_prod;
                    arm_d   = 1'b0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                data_d  = w_data;
                sat_d   = w_sat;
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            arm_q   <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            prod_q  <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            arm_q   <= arm_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            prod_q  <= prod_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_round_sat.sv
// ============================================================================
// tb_mul_round_sat : self-checking bench with a behavioural arm/fin multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_round_sat;

    localparam int A1 = 32;
    localparam int A2 = 32;
    localparam int P  = 64;
    localparam int OL = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [A1-1:0]  in_a1 = '0;
    logic [A2-1:0]  in_a2 = '0;
    logic           mul_arm;
    logic [A1-1:0]  mul_a1;
    logic [A2-1:0]  mul_a2;
    logic [P-1:0]   mul_prod;
    logic           mul_fin;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [OL-1:0]  out_data;
    logic           out_sat;

    always #5 clk = ~clk;

    mul_round_sat dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a1     (in_a1),
        .in_a2     (in_a2),
        .mul_arm   (mul_arm),
        .mul_a1    (mul_a1),
        .mul_a2    (mul_a2),
        .mul_prod  (mul_prod),
        .mul_fin   (mul_fin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Multiplier model: fin first high A2+2 cycles after arm rises, clears one cycle after arm drops.
    logic [7:0]   m_cnt = '0;
    logic         m_fin = 1'b0;
    logic [P-1:0] m_prod = '0;
    logic         fin_pulse = 1'b0;

    always @(posedge clk) begin
        if (rst || !mul_arm) begin
            m_cnt <= '0;
            m_fin <= 1'b0;
        end else begin
            if (m_cnt == 8'(A2 + 1)) begin
                m_fin  <= 1'b1;
                m_prod <= $signed({{A1{mul_a1[A1-1]}}, mul_a1}) * $signed({{A2{mul_a2[A2-1]}}, mul_a2});
            end
            if (!m_fin) m_cnt <= m_cnt + 8'd1;
        end
    end

    assign mul_prod = m_prod;
    assign mul_fin  = m_fin | fin_pulse;

    typedef struct {
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d;
        logic        s;
        int          hold;
        logic        pulse;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        s;
    } exp_t;

    vec_t vt[11];
    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
            end else begin
                mon_e = sbq.pop_front();
                chk("out_data", {32'd0, out_data}, {32'd0, mon_e.d});
                chk("out_sat", {63'd0, out_sat}, {63'd0, mon_e.s});
            end
        end
    end

    task automatic wait_accept(output logic ok);
        int w;
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 100) begin
            @(negedge clk);
            w++;
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 64'(w), 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        logic        ok;
        int          lat;
        logic [31:0] snap;
        @(posedge clk); #1;
        in_a1    = v.a1;
        in_a2    = v.a2;
        in_valid = 1'b1;
        wait_accept(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!ok) return;
        sbq.push_back('{v.d, v.s});
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("arm_after_accept", {63'd0, mul_arm}, 64'd1);
                chk("mul_a1_latched", {32'd0, mul_a1}, {32'd0, v.a1});
            end
            if (out_valid) ok = 1'b1;
        end
        chk("accept_to_valid", 64'(lat), 64'd37);
        if (!ok) return;
        snap = out_data;
        for (int k = 1; k <= v.hold; k++) begin
            @(posedge clk); #1;
            fin_pulse = v.pulse && (k == 3);
            @(negedge clk);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_data_stable", {32'd0, out_data}, {32'd0, snap});
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_arm", {63'd0, mul_arm}, 64'd0);
        end
        @(posedge clk); #1;
        fin_pulse = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_valid_low", {63'd0, out_valid}, 64'd0);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic ok;
        int   n;
        vt[0]  = '{32'h00018000, 32'h00020000, 32'h00030000, 1'b0, 10, 1'b1};
        vt[1]  = '{32'h00000001, 32'h00008000, 32'h00000001, 1'b0, 0, 1'b0};
        vt[2]  = '{32'hFFFFFFFF, 32'h00008000, 32'h00000000, 1'b0, 0, 1'b0};
        vt[3]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 2, 1'b0};
        vt[4]  = '{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1'b0};
        vt[5]  = '{32'hFFFE8000, 32'h00020000, 32'hFFFD0000, 1'b0, 0, 1'b0};
        vt[6]  = '{32'hFFFFFFFF, 32'h00018000, 32'hFFFFFFFF, 1'b0, 0, 1'b0};
        vt[7]  = '{32'h00010000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 0, 1'b0};
        vt[8]  = '{32'h80000000, 32'h00010000, 32'h80000000, 1'b0, 0, 1'b0};
        vt[9]  = '{32'h00020000, 32'h40000000, 32'h7FFFFFFF, 1'b1, 0, 1'b0};
        vt[10] = '{32'h00000001, 32'h00007FFF, 32'h00000000, 1'b0, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_arm", {63'd0, mul_arm}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
        chk("rst_mul_a1", {32'd0, mul_a1}, 64'd0);

        for (int i = 0; i < 11; i++) run_txn(vt[i]);

        // Stray fin in IDLE with in_valid pending: no accept while fin is high.
        @(posedge clk); #1;
        in_a1 = 32'h00010000;
        in_a2 = 32'h00010000;
        in_valid  = 1'b1;
        fin_pulse = 1'b1;
        @(negedge clk);
        chk("fin_idle_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        fin_pulse = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("fin_idle_no_arm", {63'd0, mul_arm}, 64'd0);
        chk("fin_idle_ready_back", {63'd0, in_ready}, 64'd1);

        // Reset five cycles into WAIT.
        @(posedge clk); #1;
        in_a1 = 32'h00050000;
        in_a2 = 32'h00070000;
        in_valid = 1'b1;
        wait_accept(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_rst_arm", {63'd0, mul_arm}, 64'd0);
        chk("midwait_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("midwait_rst_ready", {63'd0, in_ready}, 64'd1);
        run_txn('{32'h00030000, 32'h00040000, 32'h000C0000, 1'b0, 0, 1'b0});

        // Streaming with out_ready high and in_valid held across the busy window.
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_a1 = 32'h00018000;
        in_a2 = 32'h00020000;
        in_valid = 1'b1;
        wait_accept(ok);
        if (ok) sbq.push_back('{32'h00030000, 1'b0});
        @(posedge clk); #1;
        in_a1 = 32'h00030000;
        in_a2 = 32'hFFFC0000;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (in_ready) ok = 1'b1;
        end
        chk("throughput_gap", 64'(n), 64'd38);
        if (ok) sbq.push_back('{32'hFFF40000, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
